// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: key codes, controller states,
// scan result kinds and the row/column to key-code table.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_e;

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} scan_res_e;

  // One entry per row, packed as {col2, col1, col0}; col0 is the leftmost column.
  localparam logic [11:0] ROW_CODES [4] = '{
    12'h321,
    12'h654,
    12'h987,
    {KEY_HASH, 4'h0, KEY_STAR}
  };

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [11:0] codes;
    codes = ROW_CODES[row];
    return codes[{col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Drives the rows one at a time, samples the synchronized columns on the last
// cycle of each dwell and classifies every full 4-row scan as NONE/SINGLE/MULTI.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = 30000
) (
  input  logic      clock,
  input  logic      reset,
  input  logic [2:0] i_cols,
  output logic [3:0] o_rows,
  output logic      o_scan_done,
  output scan_res_e o_scan_res,
  output logic [3:0] o_scan_code
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [1:0]    r_nlow;
  logic [3:0]    r_code;
  logic          r_done;
  scan_res_e     r_res;
  logic [3:0]    r_code_out;

  logic [2:0] w_low;
  logic [1:0] w_cnt;
  logic [1:0] w_col;
  logic [2:0] w_total;
  logic       w_sample;
  logic [3:0] w_code_now;

  assign w_low    = ~i_cols;
  assign w_cnt    = {1'b0, w_low[0]} + {1'b0, w_low[1]} + {1'b0, w_low[2]};
  assign w_col    = w_low[0] ? 2'd0 : (w_low[1] ? 2'd1 : 2'd2);
  assign w_total  = {1'b0, r_nlow} + {1'b0, w_cnt};
  assign w_sample = (r_dwell == DWELL_LAST);
  // Only meaningful when the whole scan sees exactly one low column.
  assign w_code_now = (w_cnt == 2'd1) ? key_code(r_row, w_col) : r_code;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dwell    <= '0;
      r_row      <= 2'd0;
      r_nlow     <= 2'd0;
      r_code     <= KEY_NONE;
      r_done     <= 1'b0;
      r_res      <= RES_NONE;
      r_code_out <= KEY_NONE;
    end else begin
      r_done <= 1'b0;
      if (w_sample) begin
        r_dwell <= '0;
        r_row   <= r_row + 2'd1;
        if (r_row == 2'd3) begin
          r_done     <= 1'b1;
          r_res      <= (w_total == 3'd0) ? RES_NONE :
                        (w_total == 3'd1) ? RES_SINGLE : RES_MULTI;
          r_code_out <= w_code_now;
          r_nlow     <= 2'd0;
          r_code     <= KEY_NONE;
        end else begin
          // Two or more lows already means MULTI, so the count saturates at 2.
          r_nlow <= (w_total > 3'd1) ? 2'd2 : w_total[1:0];
          r_code <= w_code_now;
        end
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  assign o_rows      = ~(4'b0001 << r_row);
  assign o_scan_done = r_done;
  assign o_scan_res  = r_res;
  assign o_scan_code = r_code_out;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad controller top: column synchronizer, debounce/hold/release FSM and the
// CPU acknowledge edge detector.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 30000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int RELEASE_SCANS  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  cols,
  output logic [3:0]  rows,
  input  logic [31:0] acknowledgeKey,
  output logic [3:0]  buttonPressed,
  output logic        keyValid,
  output logic [9:0]  LED
);

  localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RLW = $clog2(RELEASE_SCANS + 1);
  localparam logic [DBW-1:0] DEB_TARGET = DBW'(DEBOUNCE_SCANS);
  localparam logic [RLW-1:0] REL_TARGET = RLW'(RELEASE_SCANS);

  logic [2:0]     r_cols_meta;
  logic [2:0]     r_cols_sync;
  logic           r_ack_d;
  state_e         r_state;
  logic [3:0]     r_cand;
  logic [DBW-1:0] r_deb_cnt;
  logic [RLW-1:0] r_rel_cnt;
  logic [3:0]     r_key;
  logic           r_valid;

  state_e         w_state_nxt;
  logic [3:0]     w_cand_nxt;
  logic [DBW-1:0] w_deb_nxt;
  logic [RLW-1:0] w_rel_nxt;
  logic [3:0]     w_key_nxt;
  logic           w_valid_nxt;
  logic [DBW-1:0] w_deb_inc;
  logic [RLW-1:0] w_rel_inc;
  logic           w_ack_edge;
  logic           w_scan_done;
  scan_res_e      w_scan_res;
  logic [3:0]     w_scan_code;
  logic           w_ack_unused;

  keypad_row_scanner #(.SCAN_CYCLES(SCAN_CYCLES)) u_scanner (
    .clock       (clock),
    .reset       (reset),
    .i_cols      (r_cols_sync),
    .o_rows      (rows),
    .o_scan_done (w_scan_done),
    .o_scan_res  (w_scan_res),
    .o_scan_code (w_scan_code)
  );

  assign w_ack_unused = ^acknowledgeKey[31:1];
  assign w_ack_edge   = acknowledgeKey[0] & ~r_ack_d;
  assign w_deb_inc    = r_deb_cnt + 1'b1;
  assign w_rel_inc    = r_rel_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cols_meta <= 3'b111;
      r_cols_sync <= 3'b111;
      r_ack_d     <= 1'b0;
      r_state     <= SCAN;
      r_cand      <= KEY_NONE;
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_key       <= KEY_NONE;
      r_valid     <= 1'b0;
    end else begin
      r_cols_meta <= cols;
      r_cols_sync <= r_cols_meta;
      r_ack_d     <= acknowledgeKey[0];
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_rel_cnt   <= w_rel_nxt;
      r_key       <= w_key_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  // Handshake: keyValid/buttonPressed hold a key until a 0->1 edge of acknowledgeKey[0]
  // arrives in HOLD; both clear on the following cycle and a still-held key is not re-sent.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_deb_nxt   = r_deb_cnt;
    w_rel_nxt   = r_rel_cnt;
    w_key_nxt   = r_key;
    w_valid_nxt = r_valid;
    case (r_state)
      SCAN: begin
        if (w_scan_done && w_scan_res == RES_SINGLE) begin
          w_cand_nxt  = w_scan_code;
          w_deb_nxt   = DBW'(1);
          w_state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (w_scan_done) begin
          if (w_scan_res == RES_SINGLE && w_scan_code == r_cand) begin
            if (w_deb_inc == DEB_TARGET) begin
              w_key_nxt   = r_cand;
              w_valid_nxt = 1'b1;
              w_deb_nxt   = '0;
              w_state_nxt = HOLD;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_deb_nxt   = '0;
            w_state_nxt = SCAN;
          end
        end
      end
      HOLD: begin
        if (w_ack_edge) begin
          w_key_nxt   = KEY_NONE;
          w_valid_nxt = 1'b0;
          w_rel_nxt   = '0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (w_scan_done) begin
          if (w_scan_res == RES_NONE) begin
            if (w_rel_inc == REL_TARGET) begin
              w_rel_nxt   = '0;
              w_state_nxt = SCAN;
            end else begin
              w_rel_nxt = w_rel_inc;
            end
          end else begin
            w_rel_nxt = '0;
          end
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_comb begin
    LED = '0;
    for (int d = 0; d < 10; d++) LED[d] = (r_key == 4'(d));
  end

  assign buttonPressed = r_key;
  assign keyValid      = r_valid;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a matrix model closes the row/column loop and a
// monitor compares every output change against the expected-event queue.
module tb_keypad_scan_ctrl;

  localparam int SC     = 4;
  localparam int SCAN_T = 4 * SC;

  logic        clock;
  logic        reset;
  logic [2:0]  cols;
  logic [3:0]  rows;
  logic [31:0] acknowledgeKey;
  logic [3:0]  buttonPressed;
  logic        keyValid;
  logic [9:0]  LED;

  logic [11:0] keys_down;
  logic [4:0]  exp_q[$];
  logic        mon_en;
  logic [4:0]  mon_prev;
  logic [4:0]  mon_cur;
  logic [4:0]  mon_exp;
  int          tests_run;
  int          tests_failed;

  keypad_scan_ctrl #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_SCANS (3),
    .RELEASE_SCANS  (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cols           (cols),
    .rows           (rows),
    .acknowledgeKey (acknowledgeKey),
    .buttonPressed  (buttonPressed),
    .keyValid       (keyValid),
    .LED            (LED)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key index = row*3 + col; a pressed key pulls its column low while its row is driven.
  always_comb begin
    cols = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!rows[r] && keys_down[r*3 + c]) cols[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] led_of(input logic [3:0] code);
    logic [9:0] v;
    v = '0;
    if (code < 4'd10) v[code] = 1'b1;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic ack_pulse();
    acknowledgeKey = 32'h1;
    tick(1);
    acknowledgeKey = 32'h0;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon_cur = {keyValid, buttonPressed};
      if (mon_cur !== mon_prev) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", mon_cur, mon_prev);
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_event", mon_cur, mon_exp);
          check("led_event", LED, led_of(mon_exp[3:0]));
        end
      end
      mon_prev = mon_cur;
    end
  end

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    mon_en         = 1'b0;
    mon_prev       = {1'b0, 4'hF};
    reset          = 1'b1;
    acknowledgeKey = 32'h0;
    keys_down      = '0;

    tick(1);
    check("rst_rows", rows, 4'b1110);
    check("rst_key", buttonPressed, 4'hF);
    check("rst_valid", keyValid, 1'b0);
    check("rst_led", LED, 10'b0);
    tick(1);
    reset = 1'b0;
    tick(3);
    check("rot_row0", rows, 4'b1110);
    tick(1);
    check("rot_row1", rows, 4'b1101);
    tick(SC);
    check("rot_row2", rows, 4'b1011);
    tick(SC);
    check("rot_row3", rows, 4'b0111);
    tick(SC);
    check("rot_wrap", rows, 4'b1110);
    mon_en = 1'b1;

    // '5' reported after debounce
    exp_q.push_back({1'b1, 4'h5});
    keys_down[4] = 1'b1;
    wait_drain("press5_latency", 5 * SCAN_T);
    check("press5_key", buttonPressed, 4'h5);
    check("press5_valid", keyValid, 1'b1);
    check("press5_led", LED, 10'b0000100000);

    // ack while still held: clears one cycle later, never re-reported
    exp_q.push_back({1'b0, 4'hF});
    acknowledgeKey = 32'h1;
    check("ack_same_cycle", buttonPressed, 4'h5);
    tick(1);
    check("ack_next_cycle", buttonPressed, 4'hF);
    check("ack_valid_clr", keyValid, 1'b0);
    tick(10 * SCAN_T);
    check("held_stays_f", buttonPressed, 4'hF);
    acknowledgeKey = 32'h0;
    keys_down = '0;
    tick(3 * SCAN_T);

    exp_q.push_back({1'b1, 4'hB});
    keys_down[11] = 1'b1;
    wait_drain("hash_latency", 6 * SCAN_T);
    check("hash_key", buttonPressed, 4'hB);
    check("hash_led", LED, 10'b0);
    exp_q.push_back({1'b0, 4'hF});
    ack_pulse();
    keys_down = '0;
    wait_drain("hash_ack", 2);
    tick(4 * SCAN_T);

    // bounce on '8': never three consecutive identical scans
    keys_down[7] = 1'b1;
    tick(2 * SCAN_T);
    keys_down[7] = 1'b0;
    tick(SCAN_T);
    keys_down[7] = 1'b1;
    tick(2 * SCAN_T);
    keys_down[7] = 1'b0;
    tick(3 * SCAN_T);
    check("bounce_key", buttonPressed, 4'hF);

    // '1' + '9' together, plus an ack edge that arrives outside HOLD
    keys_down[0] = 1'b1;
    keys_down[8] = 1'b1;
    tick(5 * SCAN_T);
    ack_pulse();
    tick(5 * SCAN_T);
    check("multi_key", buttonPressed, 4'hF);
    check("multi_valid", keyValid, 1'b0);
    keys_down = '0;
    tick(3 * SCAN_T);

    // reset while holding '7', then re-report with the key still down
    exp_q.push_back({1'b1, 4'h7});
    keys_down[6] = 1'b1;
    wait_drain("seven_latency", 6 * SCAN_T);
    check("seven_key", buttonPressed, 4'h7);
    check("seven_led", LED, 10'b0010000000);
    exp_q.push_back({1'b0, 4'hF});
    reset = 1'b1;
    tick(1);
    check("hold_rst_key", buttonPressed, 4'hF);
    check("hold_rst_valid", keyValid, 1'b0);
    check("hold_rst_rows", rows, 4'b1110);
    reset = 1'b0;
    exp_q.push_back({1'b1, 4'h7});
    wait_drain("seven_rereport", 6 * SCAN_T);
    check("seven_again", buttonPressed, 4'h7);
    exp_q.push_back({1'b0, 4'hF});
    ack_pulse();
    keys_down = '0;
    wait_drain("seven_ack", 2);
    tick(4 * SCAN_T);

    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
